wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback driver for the pipelined LEGv8 core.
- Captures the retiring instruction from the MEM stage, selects the writeback value, and drives the register-file write port (RegWrite, WriteRegister, WriteData).
- Provides same-cycle write-to-read bypass for the RF stage read ports and counts retired instructions.

Parameters:
- WIDTH, 64, datapath width in bits.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold the MEM/WB register contents.
- flush  input  1  invalidate the MEM/WB register at the next edge.
- in_valid  input  1  a valid instruction is leaving MEM.
- in_reg_write  input  1  the instruction writes a destination register.
- in_mem_to_reg  input  1  writeback value comes from memory (LDUR/LDURB).
- in_byte  input  1  byte load (LDURB); zero-extend memory data.
- in_link  input  1  BL; writeback value is PC+4.
- in_rd  input  5  destination register number.
- in_alu_result  input  WIDTH  ALU result.
- in_mem_data  input  WIDTH  data memory read data.
- in_pc_plus4  input  WIDTH  PC+4 of the instruction.
- rs1, rs2  input  5  RF-stage read register numbers.
- rf_data1, rf_data2  input  WIDTH  raw register-file read data.
- RegWrite  output  1  register-file write enable.
- WriteRegister  output  5  register-file write address.
- WriteData  output  WIDTH  register-file write data.
- fwd_data1, fwd_data2  output  WIDTH  bypassed read data to the RF stage.
- wb_valid  output  1  the MEM/WB register holds a valid instruction.
- retire_count  output  RETIRE_W  number of retired instructions.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all MEM/WB fields cleared; wb_valid=0, RegWrite=0, WriteRegister=0, WriteData=0, retire_count=0.
  - fwd_data1/2 equal rf_data1/2 while reset is held.
- Pipeline register update, evaluated each rising edge in this priority order:
  - flush=1: wb_valid<=0; other fields don't-care, but they are cleared.
  - stall=1 (and no flush): all fields hold.
  - otherwise: all in_* inputs captured; wb_valid<=in_valid.
  - Latency: inputs present before edge N appear on the write port after edge N.
- Writeback select (combinational from registered fields), in priority order:
  - link: WriteData = pc_plus4.
  - mem_to_reg with byte: WriteData = {zeros, mem_data[7:0]}.
  - mem_to_reg without byte: WriteData = mem_data.
  - else: WriteData = alu_result.
- WriteRegister = registered rd.
- RegWrite = wb_valid & reg_write & (rd != 31).
  - XZR writes are suppressed at the port.
  - The register file's own X31 zero is not relied on here.
- Stall while RegWrite=1: the same value is rewritten each cycle (idempotent, allowed).
- Bypass, per read port n:
  - fwd_datan = WriteData if RegWrite & (rsn == WriteRegister); otherwise rf_datan.
  - rsn == 31 always yields rf_datan, because RegWrite is 0 for rd=31.
  - Both ports may bypass in the same cycle.
- Retire counter:
  - increments by 1 at an edge where wb_valid=1 and stall=0, including when flush=1 (the instruction in WB retires; flush kills the incoming one).
  - wraps modulo 2^RETIRE_W.
- Reset mid-stall or mid-flush: reset wins immediately; the first post-reset edge with stall=0 captures the inputs normally.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset mid-cycle with wb_valid=1 and RegWrite=1.
  - Response: RegWrite=0, wb_valid=0, retire_count=0 immediately, with no clock edge required.
- ALU writeback:
  - Stimulus: in_valid=1, reg_write=1, rd=5, alu_result=0x1234.
  - Response: one edge later, RegWrite=1, WriteRegister=5, WriteData=0x1234; retire_count goes 0->1 on the following edge.
- Load/byte/link select:
  - Stimulus: mem_data=0xFFFF_FFFF_FFFF_FFA5, in order (a) mem_to_reg=1, byte=1; (b) byte=0; (c) link=1 with mem_to_reg=1 and pc_plus4=0x40.
  - Response: WriteData is (a) 0xA5, (b) 0xFFFF_FFFF_FFFF_FFA5, (c) 0x40.
- XZR suppression:
  - Stimulus: rd=31, reg_write=1, valid=1; rs1=31, rf_data1=0.
  - Response: RegWrite=0, fwd_data1=0; the counter still increments.
- Bypass:
  - Stimulus: WB writes X7=0xDEAD while rs1=7, rs2=7, rf_data1=rf_data2=0x1.
  - Response: fwd_data1=fwd_data2=0xDEAD.
  - Stimulus: same write with rs1=8.
  - Response: fwd_data1=0x1.
- Stall/flush:
  - Stimulus: stall for 3 cycles holding X3=0x9.
  - Response: outputs stable for 3 cycles; the counter does not increment.
  - Stimulus: stall=1 and flush=1 in the same cycle.
  - Response: wb_valid=0 after the edge, RegWrite=0.
  - Stimulus: retire_count preloaded to 0xFFFFFFFF via a long run, then one more retirement.
  - Response: retire_count wraps to 0.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM-to-WB transfer bundle for the LEGv8 pipeline: the retiring instruction's
// control bits and candidate writeback values as they leave the MEM stage.
interface wb_stage_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_reg_write;
  logic             in_mem_to_reg;
  logic             in_byte;
  logic             in_link;
  logic [4:0]       in_rd;
  logic [WIDTH-1:0] in_alu_result;
  logic [WIDTH-1:0] in_mem_data;
  logic [WIDTH-1:0] in_pc_plus4;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_byte, in_link, in_rd,
           in_alu_result, in_mem_data, in_pc_plus4
  );

  modport slave (
    input in_valid, in_reg_write, in_mem_to_reg, in_byte, in_link, in_rd,
          in_alu_result, in_mem_data, in_pc_plus4
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file write port driver with
// same-cycle write-to-read bypass and a retired-instruction counter.
module wb_stage #(
  parameter int WIDTH    = 64,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  wb_stage_if.slave           mem,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [WIDTH-1:0]    rf_data1,
  input  logic [WIDTH-1:0]    rf_data2,
  output logic                RegWrite,
  output logic [4:0]          WriteRegister,
  output logic [WIDTH-1:0]    WriteData,
  output logic [WIDTH-1:0]    fwd_data1,
  output logic [WIDTH-1:0]    fwd_data2,
  output logic                wb_valid,
  output logic [RETIRE_W-1:0] retire_count
);

  logic                valid_r;
  logic                reg_write_r;
  logic [4:0]          rd_r;
  logic [WIDTH-1:0]    data_r;
  logic [RETIRE_W-1:0] count_r;

  function automatic logic [WIDTH-1:0] wb_select(
    input logic             link,
    input logic             mem_to_reg,
    input logic             byte_load,
    input logic [WIDTH-1:0] alu_result,
    input logic [WIDTH-1:0] mem_data,
    input logic [WIDTH-1:0] pc_plus4
  );
    logic [WIDTH-1:0] sel;
    if (link) begin
      sel = pc_plus4;
    end else if (mem_to_reg && byte_load) begin
      sel = {{(WIDTH-8){1'b0}}, mem_data[7:0]};
    end else if (mem_to_reg) begin
      sel = mem_data;
    end else begin
      sel = alu_result;
    end
    return sel;
  endfunction

  // MEM/WB register; the write value and the XZR-qualified enable are resolved
  // at capture so the write port comes straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= 5'd0;
      data_r      <= '0;
    end else if (flush) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= 5'd0;
      data_r      <= '0;
    end else if (!stall) begin
      valid_r     <= mem.in_valid;
      reg_write_r <= mem.in_valid & mem.in_reg_write & (mem.in_rd != 5'd31);
      rd_r        <= mem.in_rd;
      data_r      <= wb_select(mem.in_link, mem.in_mem_to_reg, mem.in_byte,
                               mem.in_alu_result, mem.in_mem_data, mem.in_pc_plus4);
    end else begin
      valid_r     <= valid_r;
      reg_write_r <= reg_write_r;
      rd_r        <= rd_r;
      data_r      <= data_r;
    end
  end

  // Retire counter: the instruction in WB retires whenever it is not stalled,
  // even if the incoming one is being flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (valid_r && !stall) begin
      count_r <= count_r + RETIRE_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Bypass the value being written this cycle to matching read ports.
  always_comb begin
    fwd_data1 = rf_data1;
    fwd_data2 = rf_data2;
    if (reg_write_r && (rs1 == rd_r)) begin
      fwd_data1 = data_r;
    end else begin
      fwd_data1 = rf_data1;
    end
    if (reg_write_r && (rs2 == rd_r)) begin
      fwd_data2 = data_r;
    end else begin
      fwd_data2 = rf_data2;
    end
  end

  assign RegWrite      = reg_write_r;
  assign WriteRegister = rd_r;
  assign WriteData     = data_r;
  assign wb_valid      = valid_r;
  assign retire_count  = count_r;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a transaction-level model
// of the instruction currently sitting in writeback.
module tb_wb_stage;
  localparam int WIDTH = 64;
  localparam int RW    = 8;

  logic             clk = 1'b0;
  logic             reset, stall, flush;
  logic [4:0]       rs1, rs2;
  logic [WIDTH-1:0] rf_data1, rf_data2;
  logic             RegWrite, wb_valid;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData, fwd_data1, fwd_data2;
  logic [RW-1:0]    retire_count;

  wb_stage_if #(.WIDTH(WIDTH)) mif ();

  wb_stage #(.WIDTH(WIDTH), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem(mif),
    .rs1(rs1), .rs2(rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .wb_valid(wb_valid),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction held in writeback, as a plain record.
  typedef struct {
    bit          valid, rw, m2r, byt, link;
    bit [4:0]    rd;
    bit [63:0]   alu, mem, pc;
  } instr_t;

  instr_t   m_wb;
  bit [RW-1:0] m_cnt;

  function automatic instr_t empty_instr();
    instr_t e;
    e.valid = 0; e.rw = 0; e.m2r = 0; e.byt = 0; e.link = 0;
    e.rd = 0; e.alu = 0; e.mem = 0; e.pc = 0;
    return e;
  endfunction

  function automatic bit [63:0] exp_wd(input instr_t i);
    if (i.link)          return i.pc;
    if (i.m2r && i.byt)  return {56'd0, i.mem[7:0]};
    if (i.m2r)           return i.mem;
    return i.alu;
  endfunction

  function automatic bit exp_we(input instr_t i);
    return i.valid && i.rw && (i.rd != 5'd31);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wb  <= empty_instr();
      m_cnt <= '0;
    end else begin
      instr_t n;
      n.valid = mif.in_valid; n.rw = mif.in_reg_write; n.m2r = mif.in_mem_to_reg;
      n.byt = mif.in_byte; n.link = mif.in_link; n.rd = mif.in_rd;
      n.alu = mif.in_alu_result; n.mem = mif.in_mem_data; n.pc = mif.in_pc_plus4;
      if (m_wb.valid && !stall) m_cnt <= m_cnt + 1'b1;
      if (flush)       m_wb <= empty_instr();
      else if (!stall) m_wb <= n;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    bit we;
    we = exp_we(m_wb);
    chk("model_regwrite", {63'd0, RegWrite}, {63'd0, we});
    chk("model_wb_valid", {63'd0, wb_valid}, {63'd0, m_wb.valid});
    chk("model_count", {56'd0, retire_count}, {56'd0, m_cnt});
    chk("model_wreg", {59'd0, WriteRegister}, {59'd0, m_wb.rd});
    chk("model_wdata", WriteData, exp_wd(m_wb));
    chk("model_fwd1", fwd_data1, (we && rs1 == m_wb.rd) ? exp_wd(m_wb) : rf_data1);
    chk("model_fwd2", fwd_data2, (we && rs2 == m_wb.rd) ? exp_wd(m_wb) : rf_data2);
  end

  task automatic set_in(input bit v, input bit rw, input bit m2r, input bit byt,
                        input bit link, input bit [4:0] rd, input bit [63:0] alu,
                        input bit [63:0] mem, input bit [63:0] pc);
    mif.in_valid = v; mif.in_reg_write = rw; mif.in_mem_to_reg = m2r;
    mif.in_byte = byt; mif.in_link = link; mif.in_rd = rd;
    mif.in_alu_result = alu; mif.in_mem_data = mem; mif.in_pc_plus4 = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [RW-1:0] c0;
  bit            hit;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rf_data1 = 64'h1111; rf_data2 = 64'h2222;
    set_in(0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0);
    #2;
    chk("reset_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("reset_fwd1", fwd_data1, 64'h1111);
    step(); step();
    reset = 1'b0;

    // ALU writeback and one-edge-later retirement
    set_in(1, 1, 0, 0, 0, 5'd5, 64'h1234, 64'd0, 64'd0);
    step();
    chk("alu_regwrite", {63'd0, RegWrite}, 64'd1);
    chk("alu_wreg", {59'd0, WriteRegister}, 64'd5);
    chk("alu_wdata", WriteData, 64'h1234);
    chk("alu_count0", {56'd0, retire_count}, 64'd0);
    set_in(0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0);
    step();
    chk("alu_count1", {56'd0, retire_count}, 64'd1);

    // Load / byte load / link select
    set_in(1, 1, 1, 1, 0, 5'd2, 64'h77, 64'hFFFF_FFFF_FFFF_FFA5, 64'h40);
    step();
    chk("sel_byte", WriteData, 64'hA5);
    mif.in_byte = 1'b0;
    step();
    chk("sel_load", WriteData, 64'hFFFF_FFFF_FFFF_FFA5);
    mif.in_link = 1'b1;
    step();
    chk("sel_link", WriteData, 64'h40);

    // XZR suppression, counter still advances
    set_in(1, 1, 0, 0, 0, 5'd31, 64'h55, 64'd0, 64'd0);
    rs1 = 5'd31; rf_data1 = 64'd0;
    step();
    chk("xzr_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("xzr_fwd1", fwd_data1, 64'd0);
    c0 = retire_count;
    set_in(0, 0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0);
    step();
    chk("xzr_count", {56'd0, retire_count}, {56'd0, c0 + 8'd1});

    // Dual-port bypass, then a non-matching port
    set_in(1, 1, 0, 0, 0, 5'd7, 64'hDEAD, 64'd0, 64'd0);
    rs1 = 5'd7; rs2 = 5'd7; rf_data1 = 64'h1; rf_data2 = 64'h1;
    step();
    chk("byp_fwd1", fwd_data1, 64'hDEAD);
    chk("byp_fwd2", fwd_data2, 64'hDEAD);
    rs1 = 5'd8;
    #1;
    chk("byp_nomatch", fwd_data1, 64'h1);

    // Three-cycle stall holding X3=9, then stall+flush together
    set_in(1, 1, 0, 0, 0, 5'd3, 64'h9, 64'd0, 64'd0);
    step();
    c0 = retire_count;
    stall = 1'b1;
    set_in(1, 1, 0, 0, 0, 5'd12, 64'hBEEF, 64'd0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wdata", WriteData, 64'h9);
      chk("stall_wreg", {59'd0, WriteRegister}, 64'd3);
      chk("stall_count", {56'd0, retire_count}, {56'd0, c0});
    end
    flush = 1'b1;
    step();
    chk("sflush_valid", {63'd0, wb_valid}, 64'd0);
    chk("sflush_regwrite", {63'd0, RegWrite}, 64'd0);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-stall, then normal capture
    set_in(1, 1, 0, 0, 0, 5'd4, 64'hABC, 64'd0, 64'd0);
    step();
    chk("pre_reset_we", {63'd0, RegWrite}, 64'd1);
    stall = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("areset_we", {63'd0, RegWrite}, 64'd0);
    chk("areset_valid", {63'd0, wb_valid}, 64'd0);
    chk("areset_count", {56'd0, retire_count}, 64'd0);
    step();
    reset = 1'b0; stall = 1'b0;
    step();
    chk("post_reset_wdata", WriteData, 64'hABC);

    // Randomized traffic; the compare process does the checking
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 4) == 0,
             ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rf_data1 = {$urandom, $urandom}; rf_data2 = {$urandom, $urandom};
      step();
    end

    // Counter wrap: run to all-ones, one more retirement wraps to zero
    stall = 1'b0; flush = 1'b0;
    set_in(1, 1, 0, 0, 0, 5'd1, 64'd1, 64'd0, 64'd0);
    step();
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (retire_count == 8'hFF) hit = 1;
      else step();
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL wrap_reach actual=%h expected=ff (cycle budget expired)", retire_count);
    end
    step();
    chk("wrap_zero", {56'd0, retire_count}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
